imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side companion of the 64x32 instruction memory: receives a framed byte stream
//  (e.g. from a UART/debug link), assembles little-endian 32-bit words and drives the
//  memory write port from word 0 upward. Holds the core in reset (cpu_hold) while loading.
//  Checks payload integrity with an XOR checksum and reports done/error.
// PARAMETERS
//  WORDS   64  instruction-memory depth in 32-bit words (max accepted word count)
//  ADDR_W  6   word-address width, clog2(WORDS)
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  rst        in   1       asynchronous reset, active-low
//  start      in   1       1-cycle pulse: begin a new load frame
//  byte_in    in   8       stream byte
//  byte_valid in   1       byte_in valid
//  byte_ready out  1       loader can accept; transfer = byte_valid & byte_ready
//  mem_we     out  1       instruction-memory write enable (1-cycle pulse per word)
//  mem_addr   out  ADDR_W  word address of the write
//  mem_wdata  out  32      word to write
//  busy       out  1       frame in progress
//  cpu_hold   out  1       hold core in reset; equals busy
//  done       out  1       last frame completed OK (sticky until next start/reset)
//  error      out  1       last frame failed (sticky until next start/reset)
// BEHAVIOUR
//  Frame: [N] [4*N payload bytes, LSB first per word] [CHK]; CHK = XOR of all payload bytes.
//  Reset (async, rst=0): state IDLE; byte_ready, mem_we, busy, cpu_hold, done, error = 0;
//   mem_addr = 0, mem_wdata = 0, byte counter/word count/checksum = 0.
//  States:
//   IDLE   byte_ready=0. start -> HDR (clear done, error, addr, checksum).
//   HDR    byte_ready=1. On transfer: N = byte_in. N > WORDS -> ERR; N = 0 -> CHK;
//          else -> DATA.
//   DATA   byte_ready=1. Byte k (0..3) lands in mem_wdata[8k+7:8k]; checksum ^= byte.
//          After 4th byte -> WR.
//   WR     byte_ready=0, mem_we=1 for exactly one cycle at current mem_addr/mem_wdata.
//          Next cycle: if words written == N -> CHK, else mem_addr+1 and -> DATA.
//   CHK    byte_ready=1. On transfer: byte == checksum -> DONE, else -> ERR.
//   DONE   done=1, busy=0. ERR: error=1, busy=0. start in either -> HDR.
//  busy = 1 in HDR, DATA, WR, CHK. start while busy is ignored.
//  Latency: word write occurs 1 cycle after the 4th byte transfer; done/error assert
//   1 cycle after the CHK/header transfer that decides them.
//  mem_addr never wraps: N <= WORDS bounds it to WORDS-1; no write occurs for N = 0.
//  byte_valid with byte_ready=0 is not consumed (source must hold byte).
//  Checksum error does not roll back words already written.
//  Reset mid-frame aborts immediately; memory keeps partially written words.
//  Word-count comparison uses ADDR_W+1 bits; N compared as unsigned 8-bit.
// TESTING
//  1 N=1: 01,13,00,00,00,CHK=13 -> one mem_we, addr 0, data 32'h00000013; done=1.
//  2 N=2, byte_valid gaps of 0-3 cycles: words 32'h000100B7, 32'h00010117 at addr 0,1;
//    byte_ready=0 during each WR cycle; done=1; cpu_hold high from start to DONE.
//  3 N=1 payload 73,00,00,00, CHK=00 -> mem_we at addr 0 with 32'h00000073, then error=1.
//  4 N=65 (WORDS=64) -> error=1 after header, zero mem_we pulses; N=0, CHK=00 -> done=1.
//  5 N=64 full load -> last write addr 63, no wrap, done=1; start while busy has no effect.
//  6 rst=0 asserted mid-DATA (asynchronously) -> all outputs at reset values same edge-free;
//    after release, a new start + frame loads normally.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle of the imem loader.
// master: stream source / memory side (testbench); slave: the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              cpu_hold;
    logic              done;
    logic              error;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a framed byte stream [N][4*N bytes LE][XOR],
// writes words from address 0 upward, holds the core while loading and reports
// done/error for the last frame.
module imem_loader #(
    parameter int WORDS  = 64,
    parameter int ADDR_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WR,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] LP_WORDS = 8'(WORDS);

    state_t            r_state;
    logic [7:0]        r_n;
    logic [1:0]        r_bcnt;
    logic [ADDR_W:0]   r_wcnt;
    logic [7:0]        r_chk;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic              w_xfer;

    assign w_xfer         = bus.byte_valid & r_ready;
    assign bus.byte_ready = r_ready;
    assign bus.mem_we     = r_we;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.busy       = r_busy;
    assign bus.cpu_hold   = r_busy;
    assign bus.done       = r_done;
    assign bus.error      = r_error;

    // Frame FSM; every output is a register updated alongside the state transition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_bcnt  <= '0;
            r_wcnt  <= '0;
            r_chk   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        r_state <= S_HDR;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                        r_addr  <= '0;
                        r_chk   <= '0;
                        r_wcnt  <= '0;
                        r_bcnt  <= '0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (w_xfer) begin
                        r_n <= bus.byte_in;
                        if (bus.byte_in > LP_WORDS) begin
                            r_state <= S_ERR;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_error <= 1'b1;
                        end else if (bus.byte_in == 8'd0) begin
                            r_state <= S_CHK;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_wdata[{r_bcnt, 3'b000} +: 8] <= bus.byte_in;
                        r_chk  <= r_chk ^ bus.byte_in;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_state <= S_WR;
                            r_ready <= 1'b0;
                            r_we    <= 1'b1;
                            r_wcnt  <= r_wcnt + 1'b1;
                        end
                    end
                end
                S_WR: begin
                    // r_wcnt already counts the word being written this cycle
                    r_ready <= 1'b1;
                    if (8'(r_wcnt) == r_n) begin
                        r_state <= S_CHK;
                    end else begin
                        r_state <= S_DATA;
                        r_addr  <= r_addr + 1'b1;
                    end
                end
                S_CHK: begin
                    if (w_xfer) begin
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                        if (bus.byte_in == r_chk) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames built from byte queues, expected
// words and outcome derived from the frame definition.
module tb_imem_loader;
    localparam int WORDS  = 64;
    localparam int ADDR_W = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]        pl[$];
    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    int                ready_viol;
    int                hold_viol;
    int                hold_mis;
    bit                in_frame = 1'b0;

    // Write-port and hold monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
            if (bus.byte_ready !== 1'b0) ready_viol++;
        end
        if (in_frame && bus.cpu_hold !== 1'b1) hold_viol++;
        if (bus.cpu_hold !== bus.busy) hold_mis++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] xor_of();
        logic [7:0] x = 8'h00;
        foreach (pl[i]) x = x ^ pl[i];
        return x;
    endfunction

    function automatic logic [31:0] word_of(input int i);
        return {pl[4*i+3], pl[4*i+2], pl[4*i+1], pl[4*i]};
    endfunction

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        ready_viol = 0;
        hold_viol  = 0;
        hold_mis   = 0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        bus.byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (bus.byte_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            checks++; errors++;
            $display("FAIL byte_accept: byte_ready=%b, required 1 within 100 cycles", bus.byte_ready);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic run_frame(input int n, input logic [7:0] chk, input int maxgap,
                             input int busy_start_at);
        clear_log();
        pulse_start();
        in_frame = 1'b1;
        if (n > WORDS) begin
            in_frame = 1'b0;
            send_byte(8'(n), $urandom_range(maxgap, 0));
        end else begin
            send_byte(8'(n), $urandom_range(maxgap, 0));
            for (int i = 0; i < pl.size(); i++) begin
                if (i == busy_start_at) pulse_start();
                send_byte(pl[i], $urandom_range(maxgap, 0));
            end
            in_frame = 1'b0;
            send_byte(chk, $urandom_range(maxgap, 0));
        end
    endtask

    task automatic test_reset();
        logic [45:0] obs;
        rst = 1'b0;
        bus.start = 1'b0; bus.byte_valid = 1'b0; bus.byte_in = 8'h00;
        repeat (2) @(negedge clk);
        obs = {bus.byte_ready, bus.mem_we, bus.busy, bus.cpu_hold, bus.done, bus.error,
               bus.mem_addr, bus.mem_wdata};
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h, required 0", obs);
        end
        rst = 1'b1;
        bus.byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.byte_valid = 1'b0;
        obs = {bus.byte_ready, bus.mem_we, bus.busy, bus.cpu_hold, bus.done, bus.error,
               bus.mem_addr, bus.mem_wdata};
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL idle_outputs: got %h, required 0", obs);
        end
    endtask

    task automatic test_single();
        pl = '{8'h13, 8'h00, 8'h00, 8'h00};
        run_frame(1, 8'h13, 0, -1);
        checks++;
        if (wr_data.size() !== 1) begin
            errors++; $display("FAIL single_count: got %0d writes, required 1", wr_data.size());
        end else begin
            checks++;
            if (wr_addr[0] !== '0 || wr_data[0] !== 32'h00000013) begin
                errors++; $display("FAIL single_word: got %0d:%h, required 0:00000013", wr_addr[0], wr_data[0]);
            end
        end
        checks++;
        if ({bus.done, bus.error, bus.busy} !== 3'b100) begin
            errors++; $display("FAIL single_status: done/error/busy=%b, required 100", {bus.done, bus.error, bus.busy});
        end
    endtask

    task automatic test_gaps();
        pl = '{8'hB7, 8'h00, 8'h01, 8'h00, 8'h17, 8'h01, 8'h01, 8'h00};
        run_frame(2, xor_of(), 3, -1);
        checks++;
        if (wr_data.size() !== 2) begin
            errors++; $display("FAIL gaps_count: got %0d writes, required 2", wr_data.size());
        end
        for (int i = 0; i < 2 && i < wr_data.size(); i++) begin
            checks++;
            if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== word_of(i)) begin
                errors++; $display("FAIL gaps_word%0d: got %0d:%h, required %0d:%h", i, wr_addr[i], wr_data[i], i, word_of(i));
            end
        end
        checks++;
        if (ready_viol !== 0) begin
            errors++; $display("FAIL gaps_ready_in_wr: got %0d cycles with byte_ready=1, required 0", ready_viol);
        end
        checks++;
        if (hold_viol !== 0 || hold_mis !== 0) begin
            errors++; $display("FAIL gaps_cpu_hold: got %0d drops / %0d busy mismatches, required 0/0", hold_viol, hold_mis);
        end
        checks++;
        if ({bus.done, bus.error} !== 2'b10) begin
            errors++; $display("FAIL gaps_status: done/error=%b, required 10", {bus.done, bus.error});
        end
    endtask

    task automatic test_bad_chk();
        pl = '{8'h73, 8'h00, 8'h00, 8'h00};
        run_frame(1, 8'h00, 1, -1);
        checks++;
        if (wr_data.size() !== 1 || wr_data[0] !== 32'h00000073 || wr_addr[0] !== '0) begin
            errors++; $display("FAIL badchk_write: got %0d writes, required 1 write 0:00000073", wr_data.size());
        end
        checks++;
        if ({bus.done, bus.error, bus.cpu_hold} !== 3'b010) begin
            errors++; $display("FAIL badchk_status: done/error/hold=%b, required 010", {bus.done, bus.error, bus.cpu_hold});
        end
    endtask

    task automatic test_oversize_and_empty();
        pl.delete();
        run_frame(WORDS + 1, 8'h00, 0, -1);
        checks++;
        if (wr_data.size() !== 0 || {bus.done, bus.error, bus.busy} !== 3'b010) begin
            errors++; $display("FAIL oversize: got %0d writes, done/error/busy=%b, required 0 writes, 010", wr_data.size(), {bus.done, bus.error, bus.busy});
        end
        run_frame(0, 8'h00, 2, -1);
        checks++;
        if (wr_data.size() !== 0 || {bus.done, bus.error} !== 2'b10) begin
            errors++; $display("FAIL empty_frame: got %0d writes, done/error=%b, required 0 writes, 10", wr_data.size(), {bus.done, bus.error});
        end
    endtask

    task automatic test_full();
        pl.delete();
        for (int i = 0; i < 4 * WORDS; i++) pl.push_back(8'($urandom));
        run_frame(WORDS, xor_of(), 1, 161);
        checks++;
        if (wr_data.size() !== WORDS) begin
            errors++; $display("FAIL full_count: got %0d writes, required %0d", wr_data.size(), WORDS);
        end
        for (int i = 0; i < WORDS && i < wr_data.size(); i++) begin
            checks++;
            if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== word_of(i)) begin
                errors++; $display("FAIL full_word%0d: got %0d:%h, required %0d:%h", i, wr_addr[i], wr_data[i], i, word_of(i));
            end
        end
        checks++;
        if ({bus.done, bus.error} !== 2'b10 || bus.mem_addr !== ADDR_W'(WORDS - 1)) begin
            errors++; $display("FAIL full_status: done/error=%b addr=%0d, required 10 addr=%0d", {bus.done, bus.error}, bus.mem_addr, WORDS - 1);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int n;
            bit corrupt;
            logic [7:0] chk;
            int exp_n;
            n = $urandom_range(WORDS + 6, 0);
            corrupt = 1'($urandom_range(1, 0));
            pl.delete();
            if (n <= WORDS) for (int i = 0; i < 4 * n; i++) pl.push_back(8'($urandom));
            chk = xor_of() ^ (corrupt ? 8'(1 + $urandom_range(254, 0)) : 8'h00);
            exp_n = (n <= WORDS) ? n : 0;
            run_frame(n, chk, 2, -1);
            checks++;
            if (wr_data.size() !== exp_n) begin
                errors++; $display("FAIL rand%0d_count: got %0d writes, required %0d", t, wr_data.size(), exp_n);
            end
            for (int i = 0; i < exp_n && i < wr_data.size(); i++) begin
                checks++;
                if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== word_of(i)) begin
                    errors++; $display("FAIL rand%0d_word%0d: got %0d:%h, required %0d:%h", t, i, wr_addr[i], wr_data[i], i, word_of(i));
                end
            end
            checks++;
            if (bus.done !== (n <= WORDS && !corrupt) || bus.error !== !(n <= WORDS && !corrupt)) begin
                errors++; $display("FAIL rand%0d_status: n=%0d done/error=%b%b, required %b%b", t, n, bus.done, bus.error, (n <= WORDS && !corrupt), !(n <= WORDS && !corrupt));
            end
        end
    endtask

    task automatic test_async_reset();
        logic [45:0] obs;
        pl.delete();
        for (int i = 0; i < 12; i++) pl.push_back(8'($urandom));
        clear_log();
        pulse_start();
        send_byte(8'd3, 0);
        for (int i = 0; i < 5; i++) send_byte(pl[i], 0);
        checks++;
        if (wr_data.size() !== 1) begin
            errors++; $display("FAIL prereset_writes: got %0d, required 1", wr_data.size());
        end
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        obs = {bus.byte_ready, bus.mem_we, bus.busy, bus.cpu_hold, bus.done, bus.error,
               bus.mem_addr, bus.mem_wdata};
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL async_reset: got %h, required 0", obs);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pl.delete();
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
        run_frame(2, xor_of(), 1, -1);
        checks++;
        if (wr_data.size() !== 2 || wr_addr[0] !== '0 || wr_data[0] !== word_of(0)
            || wr_addr[1] !== ADDR_W'(1) || wr_data[1] !== word_of(1)) begin
            errors++; $display("FAIL postreset_words: got %0d writes, required 2 words %h %h", wr_data.size(), word_of(0), word_of(1));
        end
        checks++;
        if ({bus.done, bus.error} !== 2'b10) begin
            errors++; $display("FAIL postreset_status: done/error=%b, required 10", {bus.done, bus.error});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gaps();
        test_bad_chk();
        test_oversize_and_empty();
        test_full();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
